tanh_out_fifo: RTL and testbench
================================

# tanh_out_fifo

Elastic output stage placed directly downstream of the pipelined tanh core. It accepts Q2.12 results over a valid/ready handshake, optionally clamps them to the legal tanh range [-1.0, +1.0], and buffers them in a parameterised FIFO. The core stalls globally whenever its `i_ready` is low, so this block's registered-full `o_ready` isolates the core from combinational backpressure paths and rate jitter in the downstream consumer.

## Interface
- `DEPTH`, default 8: number of entries. Must be a power of two, ≥ 2.
- `CLAMP_EN`, default 1: 1 = saturate results to ±1.0 on write; 0 = pass data unmodified.
- `clk`, input, 1: clock. One clock domain only.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `i_fx`, input, 14: signed Q2.12 result from the tanh core.
- `i_valid`, input, 1: `i_fx` is valid.
- `o_ready`, output, 1: space is available. Drives the tanh core's `i_ready`.
- `o_fx`, output, 14: signed Q2.12 head-of-FIFO value.
- `o_sat`, output, 1: the head entry was clamped on write.
- `o_valid`, output, 1: `o_fx` and `o_sat` are valid.
- `i_ready`, input, 1: downstream accepts the head this cycle.
- `o_level`, output, $clog2(DEPTH+1): current occupancy.

## Operation
- **Write** occurs when `i_valid && o_ready`.
- **Read** occurs when `o_valid && i_ready`.
- **Storage:** a DEPTH × 15-bit array holding {sat, fx}. Write and read pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy is kept in a separate counter, `level`.
- **Clamp** (CLAMP_EN=1), applied on the write path with a signed compare:
  - `i_fx > 14'sh1000` (+1.0) stores 14'sh1000 with sat=1.
  - `i_fx < 14'sh3000` (−1.0) stores 14'sh3000 with sat=1.
  - Otherwise stores `i_fx` with sat=0.
  - ±1.0 exactly is not clamped.
- **Pass-through** (CLAMP_EN=0): stores `i_fx` unchanged with sat=0.
- `o_ready = (level != DEPTH)`. It is derived only from the registered level, so there is no combinational path from `i_ready`.
- `o_valid = (level != 0)`.
- `o_fx`/`o_sat` are the array entry at the read pointer. They may be a combinational read of registered storage.
- **Level update:**
  - write only: +1
  - read only: −1
  - both or neither: unchanged
- **Full:** `o_ready`=0, so a write is impossible. A read while full frees the slot for the next cycle, not the same cycle. There is no same-cycle pass-through.
- **Empty:** `o_valid`=0, so a read is impossible. A write while empty becomes visible the following cycle. There is no bypass.
- **Simultaneous read and write at partial occupancy:** both pointers advance and level is unchanged.
- **Held data:** `o_fx` must stay stable while `o_valid && !i_ready`.

## Timing
- **Reset values:** pointers=0, level=0, `o_valid`=0, `o_ready`=1, `o_level`=0. `o_fx`/`o_sat` are don't-care while `o_valid`=0; the bench checks them as 0 after reset.
- **Reset mid-operation:** contents are discarded immediately (asynchronously). The first post-reset write appears on `o_fx` one cycle later.
- **Latency:** write at edge N makes data valid at the output after edge N, i.e. 1 cycle.
- **Throughput:** 1 entry/cycle sustained whenever 0 < level < DEPTH.
- **Backpressure:** `o_ready` falls on the edge where level reaches DEPTH. It rises on the edge after the first read from full.

## Structure
- **Shared package `tanh_pkg`:**
  - `FX_W`=14, `FX_FRAC`=12
  - `typedef logic signed [FX_W-1:0] fx_t`
  - `FX_ONE`=14'sh1000, `FX_NEG_ONE`=14'sh3000
  - The tanh core will also import this package.
- **Sub-module `tanh_sat`:** the combinational clamp, fx_t in → {fx_t out, sat}. It is reusable by other activation stages.
- **Top level:** the FIFO array, pointer and level control live in the top module.

## Test plan
- **Reset then single write:** `i_fx`=14'sh0800, `i_valid`=1 for 1 cycle, `i_ready`=0 → next cycle `o_valid`=1, `o_fx`=14'sh0800, `o_sat`=0, `o_level`=1.
- **Clamp:** writes 14'sh1800, 14'sh2400, 14'sh1000 → outputs 14'sh1000/sat=1, 14'sh3000/sat=1, 14'sh1000/sat=0. With CLAMP_EN=0, the same writes are unchanged and sat=0.
- **Fill to full** (DEPTH=8, `i_ready`=0): writes 1..9 → `o_ready`=0 after the 8th write, the 9th is not accepted, `o_level`=8. Raise `i_ready` for 1 cycle → `o_fx`=1 consumed, `o_ready`=1 on the following cycle.
- **Streaming:** `i_valid`=`i_ready`=1 for 20 cycles with incrementing data → output order is preserved, level stays at 1, no gaps after the first item, pointers wrap correctly.
- **Random valid/ready** (50% each, 1000 items): the scoreboard matches a reference queue, `o_fx` is stable while stalled, and the level never exceeds DEPTH.
- **Async reset mid-stream** with level=5, `rst` asserted between clock edges → `o_valid`=0, `o_ready`=1 and `o_level`=0 immediately. After reset, the first write appears 1 cycle later.

Source files
------------

// File: rtl/tanh_pkg.sv
// Shared fixed-point definitions for the tanh datapath.
// Q2.12 signed format: 14 bits total, 12 fractional bits.
// Imported by the tanh core, the clamp helper and the output FIFO.
package tanh_pkg;

  localparam int FX_W    = 14;
  localparam int FX_FRAC = 12;

  typedef logic signed [FX_W-1:0] fx_t;

  localparam fx_t FX_ONE     = 14'sh1000;  // +1.0
  localparam fx_t FX_NEG_ONE = 14'sh3000;  // -1.0

  // One FIFO entry: clamp flag plus the stored value.
  typedef struct packed {
    logic sat;
    fx_t  fx;
  } fx_entry_t;

endpackage

// File: rtl/tanh_sat.sv
// Combinational clamp of a Q2.12 value to the legal tanh range [-1.0, +1.0].
// Ports:
//   fx_in  - signed Q2.12 value to clamp
//   fx_out - clamped value (or fx_in unchanged when CLAMP_EN = 0)
//   sat    - high when fx_out differs from fx_in because of clamping
// Exactly +1.0 and -1.0 pass through without setting sat.
module tanh_sat
  import tanh_pkg::*;
#(
  parameter bit CLAMP_EN = 1'b1
) (
  input  fx_t  fx_in,
  output fx_t  fx_out,
  output logic sat
);

  always_comb begin
    fx_out = fx_in;
    sat    = 1'b0;
    if (CLAMP_EN) begin
      if (fx_in > FX_ONE) begin
        fx_out = FX_ONE;
        sat    = 1'b1;
      end else if (fx_in < FX_NEG_ONE) begin
        fx_out = FX_NEG_ONE;
        sat    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tanh_out_fifo.sv
// Elastic output stage behind the pipelined tanh core.
// Optionally clamps incoming Q2.12 results to [-1.0, +1.0] and buffers them
// in a DEPTH-entry FIFO. o_ready depends only on the registered occupancy, so
// downstream backpressure never reaches the core combinationally.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   i_fx, i_valid    - result from the core; o_ready back to the core
//   o_fx, o_sat      - head-of-FIFO value and its clamp flag
//   o_valid, i_ready - output handshake to the consumer
//   o_level          - current occupancy (0..DEPTH)
module tanh_out_fifo
  import tanh_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  fx_t                        i_fx,
  input  logic                       i_valid,
  output logic                       o_ready,
  output fx_t                        o_fx,
  output logic                       o_sat,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  fx_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  fx_t               sat_fx;
  logic              sat_flag;
  logic              wr_en;
  logic              rd_en;

  tanh_sat #(
    .CLAMP_EN (CLAMP_EN)
  ) u_sat (
    .fx_in  (i_fx),
    .fx_out (sat_fx),
    .sat    (sat_flag)
  );

  assign o_ready = (level != LW'(DEPTH));
  assign o_valid = (level != '0);
  assign wr_en   = i_valid && o_ready;
  assign rd_en   = o_valid && i_ready;

  // Head is a plain read of registered storage; no bypass from the write side.
  assign o_fx    = mem[rd_ptr].fx;
  assign o_sat   = mem[rd_ptr].sat;
  assign o_level = level;

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= '{sat: sat_flag, fx: sat_fx};
    end
  end

  // Pointers are log2(DEPTH) wide, so increment wraps without compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !rd_en) begin
        level <= level + LW'(1);
      end else if (rd_en && !wr_en) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tanh_out_fifo.sv
// Self-checking bench for tanh_out_fifo. Two instances (clamp on / clamp off)
// share the same stimulus; each is compared against its own reference queue.
module tb_tanh_out_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] i_fx;
  logic        i_valid;
  logic        i_ready;

  logic        o_ready_c, o_valid_c, o_sat_c;
  logic [13:0] o_fx_c;
  logic [3:0]  o_level_c;
  logic        o_ready_p, o_valid_p, o_sat_p;
  logic [13:0] o_fx_p;
  logic [3:0]  o_level_p;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] q_c[$];
  logic [14:0] q_p[$];

  always #5 clk = ~clk;

  tanh_out_fifo #(.DEPTH(DEPTH), .CLAMP_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .i_fx(i_fx), .i_valid(i_valid), .o_ready(o_ready_c),
    .o_fx(o_fx_c), .o_sat(o_sat_c), .o_valid(o_valid_c), .i_ready(i_ready),
    .o_level(o_level_c)
  );

  tanh_out_fifo #(.DEPTH(DEPTH), .CLAMP_EN(1'b0)) dut_p (
    .clk(clk), .rst(rst), .i_fx(i_fx), .i_valid(i_valid), .o_ready(o_ready_p),
    .o_fx(o_fx_p), .o_sat(o_sat_p), .o_valid(o_valid_p), .i_ready(i_ready),
    .o_level(o_level_p)
  );

  // Reference clamp from the range rule: values beyond +/-1.0 (4096) saturate.
  function automatic logic [14:0] ref_entry(input logic [13:0] x, input bit en);
    int v;
    v = int'($signed(x));
    if (en && v > 4096)  return {1'b1, 14'h1000};
    if (en && v < -4096) return {1'b1, 14'h3000};
    return {1'b0, x};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/valid_c"}, 32'(o_valid_c), 32'(q_c.size() != 0));
    chk({tag, "/ready_c"}, 32'(o_ready_c), 32'(q_c.size() != DEPTH));
    chk({tag, "/level_c"}, 32'(o_level_c), 32'(q_c.size()));
    chk({tag, "/valid_p"}, 32'(o_valid_p), 32'(q_p.size() != 0));
    chk({tag, "/level_p"}, 32'(o_level_p), 32'(q_p.size()));
    if (q_c.size() != 0) chk({tag, "/head_c"}, 32'({o_sat_c, o_fx_c}), 32'(q_c[0]));
    if (q_p.size() != 0) chk({tag, "/head_p"}, 32'({o_sat_p, o_fx_p}), 32'(q_p[0]));
  endtask

  // One clock: apply inputs, advance the reference at the edge, check after it.
  task automatic cycle(input string tag, input logic [13:0] fx, input logic vld, input logic rdy,
                       output bit wrote);
    bit          wr, rd, stall;
    logic [13:0] held;
    i_fx    = fx;
    i_valid = vld;
    i_ready = rdy;
    wr    = vld && (q_c.size() < DEPTH);
    rd    = rdy && (q_c.size() > 0);
    stall = o_valid_c && !rdy;
    held  = o_fx_c;
    @(posedge clk);
    if (rd) begin
      void'(q_c.pop_front());
      void'(q_p.pop_front());
    end
    if (wr) begin
      q_c.push_back(ref_entry(fx, 1'b1));
      q_p.push_back(ref_entry(fx, 1'b0));
    end
    wrote = wr;
    #1;
    check_outputs(tag);
    chk({tag, "/level_bound"}, 32'(o_level_c <= 4'(DEPTH)), 32'd1);
    if (stall) chk({tag, "/held"}, 32'(o_fx_c), 32'(held));
  endtask

  task automatic clear_model();
    q_c.delete();
    q_p.delete();
  endtask

  initial begin
    bit          w;
    int          wcount;
    int          cyc;
    logic [13:0] clamp_vals [3];
    clamp_vals[0] = 14'h1800;
    clamp_vals[1] = 14'h2400;
    clamp_vals[2] = 14'h1000;

    rst = 1'b1; i_fx = '0; i_valid = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset/fx", 32'(o_fx_c), 32'd0);
    chk("reset/sat", 32'(o_sat_c), 32'd0);
    #3 rst = 1'b0;

    // Single write, held at output.
    cycle("single", 14'h0800, 1'b1, 1'b0, w);
    cycle("single_hold", 14'h0, 1'b0, 1'b0, w);
    chk("single/fx", 32'(o_fx_c), 32'h0800);
    cycle("single_drain", 14'h0, 1'b0, 1'b1, w);

    // Clamp boundaries on both instances.
    foreach (clamp_vals[i]) cycle("clamp_wr", clamp_vals[i], 1'b1, 1'b0, w);
    chk("clamp/first", 32'({o_sat_c, o_fx_c}), 32'({1'b1, 14'h1000}));
    chk("clamp/first_p", 32'({o_sat_p, o_fx_p}), 32'({1'b0, 14'h1800}));
    for (int i = 0; i < 3; i++) cycle("clamp_rd", 14'h0, 1'b0, 1'b1, w);

    // Fill to full; ninth write must be refused.
    for (int i = 1; i <= 9; i++) cycle("fill", 14'(i), 1'b1, 1'b0, w);
    chk("fill/ready", 32'(o_ready_c), 32'd0);
    chk("fill/level", 32'(o_level_c), 32'd8);
    chk("fill/head", 32'(o_fx_c), 32'd1);
    cycle("full_rd", 14'h0, 1'b0, 1'b1, w);
    chk("full_rd/ready", 32'(o_ready_c), 32'd1);
    chk("full_rd/head", 32'(o_fx_c), 32'd2);
    for (int i = 0; i < 7; i++) cycle("drain", 14'h0, 1'b0, 1'b1, w);

    // Streaming: one in, one out per cycle.
    for (int i = 0; i < 20; i++) cycle("stream", 14'(16 + i), 1'b1, 1'b1, w);
    cycle("stream_end", 14'h0, 1'b0, 1'b1, w);

    // Random valid/ready against the reference queues.
    wcount = 0;
    cyc    = 0;
    while (wcount < 1000 && cyc < 10000) begin
      cycle("rand", 14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), w);
      if (w) wcount++;
      cyc++;
    end
    chk("rand/budget", 32'(wcount >= 1000), 32'd1);
    while (q_c.size() > 0 && cyc < 10100) begin
      cycle("rand_drain", 14'h0, 1'b0, 1'b1, w);
      cyc++;
    end

    // Async reset mid-stream at level 5.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 14'(100 + i), 1'b1, 1'b0, w);
    chk("pre_rst/level", 32'(o_level_c), 32'd5);
    #3 rst = 1'b1;
    #1;
    clear_model();
    chk("async/valid", 32'(o_valid_c), 32'd0);
    chk("async/ready", 32'(o_ready_c), 32'd1);
    chk("async/level", 32'(o_level_c), 32'd0);
    #2 rst = 1'b0;
    i_valid = 1'b0;
    cycle("post_rst", 14'h0123, 1'b1, 1'b0, w);
    chk("post_rst/fx", 32'(o_fx_c), 32'h0123);
    cycle("post_rst_rd", 14'h0, 1'b0, 1'b1, w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
